// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done handshake and operand/result bus of the bit-serial adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             err;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, carry, err
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, carry, err
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one full-adder stage, LSB first
// Optional reference self-check enabled by SERIAL_ADDER_SELFCHECK_EN.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CW    = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus_if
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             cr_q;
  logic             busy_q;
  logic             done_q;
  logic             carry_q;

  logic             s_d;
  logic             co_d;
  logic [WIDTH-1:0] res_d;
  logic             last_d;

  // The single full-adder cell fed by the low bits of the operand shifters.
  always_comb begin
    s_d    = sa_q[0] ^ sb_q[0] ^ cr_q;
    co_d   = (sa_q[0] & sb_q[0]) | (cr_q & (sa_q[0] ^ sb_q[0]));
    res_d  = {s_d, res_q[WIDTH-1:1]};
    last_d = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef SERIAL_ADDER_SELFCHECK_EN
  logic [WIDTH:0]   ref_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             op_c_q;
  logic             err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q  <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      op_c_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (state_q == IDLE && bus_if.start) begin
      ref_q  <= {1'b0, bus_if.a} + {1'b0, bus_if.b} + {{WIDTH{1'b0}}, bus_if.cin};
      op_a_q <= bus_if.a;
      op_b_q <= bus_if.b;
      op_c_q <= bus_if.cin;
      err_q  <= 1'b0;
    end else if (state_q == SHIFT && last_d) begin
      err_q <= ({co_d, res_d} != ref_q);
`ifndef SYNTHESIS
      if ({co_d, res_d} != ref_q)
        $display("serial_adder selfcheck: a=%0h b=%0h cin=%0b result=%0h ref=%0h",
                 op_a_q, op_b_q, op_c_q, {co_d, res_d}, ref_q);
`endif
    end
  end

  assign bus_if.err = err_q;
`else
  assign bus_if.err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus_if.start) begin
            sa_q    <= bus_if.a;
            sb_q    <= bus_if.b;
            cr_q    <= bus_if.cin;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          res_q <= res_d;
          sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
          sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
          cr_q  <= co_d;
          cnt_q <= cnt_q + CW'(1);
          // Outputs are published on the same edge that consumes the MSB.
          if (last_d) begin
            sum_q   <= res_d;
            carry_q <= co_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_if.busy  = busy_q;
  assign bus_if.done  = done_q;
  assign bus_if.sum   = sum_q;
  assign bus_if.carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH=8 and WIDTH=2
`timescale 1ns/1ps
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [8:0] exp8[$];
  logic [2:0] exp2[$];

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(2)) bus2 ();

  serial_adder #(.WIDTH(8), .CW(6)) dut8 (.clk(clk), .rst_n(rst_n), .bus_if(bus8.slave));
  serial_adder #(.WIDTH(2), .CW(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus_if(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; drives the start for the following posedge and
  // returns at the negedge after the done pulse has cleared.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input bit chk_sum, input bit exp_err, input bit corrupt);
    int busy_cnt;
    int lat;
    bit seen;
    logic v;
    logic [8:0] e;
    exp8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = c;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
    busy_cnt = 0; lat = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus8.done) begin seen = 1; break; end
      if (bus8.busy) busy_cnt++;
      if (corrupt && i == 2) begin
        v = dut8.cr_q;
        if (v) force dut8.cr_q = 1'b0;
        else   force dut8.cr_q = 1'b1;
        #1 release dut8.cr_q;
      end
      lat++;
      @(negedge clk);
    end
    e = exp8.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout8: no done within 40 cycles, expected result %0h", e);
    end else begin
      if (lat !== 8) begin errors++; $display("FAIL latency8: got %0d expected 8", lat); end
      checks++;
      if (busy_cnt !== 8) begin errors++; $display("FAIL busy_cycles8: got %0d expected 8", busy_cnt); end
      if (chk_sum) begin
        checks++;
        if ({bus8.carry, bus8.sum} !== e) begin
          errors++;
          $display("FAIL result8: got %0h expected %0h", {bus8.carry, bus8.sum}, e);
        end
      end
      checks++;
      if (bus8.err !== exp_err) begin errors++; $display("FAIL err8: got %0b expected %0b", bus8.err, exp_err); end
      checks++;
      if (bus8.busy !== 1'b0) begin errors++; $display("FAIL busy_at_done8: got %0b expected 0", bus8.busy); end
    end
    @(negedge clk);
    checks++;
    if (bus8.done !== 1'b0) begin errors++; $display("FAIL done_pulse8: got %0b expected 0", bus8.done); end
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic c);
    int lat;
    bit seen;
    logic [2:0] e;
    exp2.push_back({1'b0, a} + {1'b0, b} + 3'(c));
    bus2.start = 1'b1; bus2.a = a; bus2.b = b; bus2.cin = c;
    @(negedge clk);
    bus2.start = 1'b0; bus2.a = ~a; bus2.b = ~b; bus2.cin = ~c;
    lat = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus2.done) begin seen = 1; break; end
      lat++;
      @(negedge clk);
    end
    e = exp2.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout2: a=%0d b=%0d cin=%0b no done", a, b, c);
    end else if ({bus2.carry, bus2.sum} !== e || lat !== 2 || bus2.err !== 1'b0) begin
      errors++;
      $display("FAIL exhaustive2: a=%0d b=%0d cin=%0b got %0d lat %0d err %0b expected %0d lat 2 err 0",
               a, b, c, {bus2.carry, bus2.sum}, lat, bus2.err, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.carry, bus8.err} !== 12'h0) begin
      errors++;
      $display("FAIL reset8: busy/done/sum/carry/err got %0h expected 0",
               {bus8.busy, bus8.done, bus8.sum, bus8.carry, bus8.err});
    end
    checks++;
    if ({bus2.busy, bus2.done, bus2.sum, bus2.carry, bus2.err} !== 6'h0) begin
      errors++;
      $display("FAIL reset2: got %0h expected 0", {bus2.busy, bus2.done, bus2.sum, bus2.carry, bus2.err});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run8(8'h00, 8'h00, 1'b0, 1, 0, 0);
    run8(8'hFF, 8'h01, 1'b0, 1, 0, 0);
    run8(8'hA5, 8'h5A, 1'b1, 1, 0, 0);
    run8(8'h3C, 8'h0F, 1'b0, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1, 0, 0);
  endtask

  task automatic test_ignore_start();
    int dones;
    logic [8:0] e;
    logic [8:0] got;
    exp8.push_back(9'h012 + 9'h034);
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    dones = 0; got = '0;
    for (int i = 0; i < 16; i++) begin
      if (bus8.done) begin
        dones++;
        if (dones == 1) got = {bus8.carry, bus8.sum};
      end
      @(negedge clk);
    end
    e = exp8.pop_front();
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
    checks++;
    if (got !== e) begin errors++; $display("FAIL ignore_result: got %0h expected %0h", got, e); end
    checks++;
    if (bus8.busy !== 1'b0) begin errors++; $display("FAIL ignore_busy: got %0b expected 0", bus8.busy); end
  endtask

  task automatic test_reset_mid_shift();
    bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus8.busy !== 1'b1) begin errors++; $display("FAIL busy_before_abort: got %0b expected 1", bus8.busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.sum, bus8.carry} !== 11'h0) begin
      errors++;
      $display("FAIL abort_outputs: got %0h expected 0", {bus8.busy, bus8.done, bus8.sum, bus8.carry});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus8.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %0b expected 0", bus8.done); end
      @(negedge clk);
    end
    run8(8'h01, 8'h02, 1'b1, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          run2(2'(a), 2'(b), 1'(c));
  endtask

  task automatic test_selfcheck();
`ifdef SERIAL_ADDER_SELFCHECK_EN
    run8(8'hFF, 8'h01, 1'b0, 0, 1, 1);
`else
    run8(8'hFF, 8'h01, 1'b0, 0, 0, 1);
`endif
    run8(8'h3C, 8'h0F, 1'b0, 1, 0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_reset_mid_shift();
    test_back_to_back();
    test_selfcheck();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
